vga_timing: RTL and testbench

- Free-running VGA raster timing generator on the pixel clock; default mode is 640x480@60 (800x525 total).
- Sits directly downstream of the power-on reset stage. The top level inverts the POR's active-low output into this block's `reset` input.
- Produces pixel coordinates, sync, data-enable and frame/line strobes for the pixel-generation and output stages.

---
 rtl/vga_timing.sv | 133 +++++++++++++
 tb/tb_vga_timing.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster timing generator on the pixel clock.
// Default mode 640x480@60 (800x525 total). All outputs registered and
// decoded from the next counter values, so sync/de/strobes line up with
// the sx/sy presented in the same cycle.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] sx,
    output logic [11:0] sy,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 12 bits wide, so neither total may exceed 4096.
    generate
        if ((H_TOTAL > 4096) || (V_TOTAL > 4096) || (H_TOTAL == 0) || (V_TOTAL == 0)) begin : g_size_check
            $error("vga_timing: H_TOTAL and V_TOTAL must be in 1..4096");
        end
    endgenerate

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // Decode boundaries kept 13 bits wide so an end bound of 4096 does not
    // truncate to zero.
    localparam logic [12:0] H_DE_END   = 13'(H_ACTIVE);
    localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_DE_END   = 13'(V_ACTIVE);
    localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

    logic        h_wrap;
    logic        v_wrap;
    logic [11:0] next_sx;
    logic [11:0] next_sy;
    logic [12:0] nx_ext;
    logic [12:0] ny_ext;
    logic        in_hsync;
    logic        in_vsync;
    logic        next_de;
    logic        next_hsync;
    logic        next_vsync;
    logic        next_line_start;
    logic        next_frame_start;

    // Next raster position: sx advances every clock, sy on each line wrap.
    always_comb begin
        h_wrap  = (sx == H_LAST);
        v_wrap  = (sy == V_LAST);
        next_sx = sx + 12'd1;
        next_sy = sy;
        if (h_wrap) begin
            next_sx = '0;
            next_sy = v_wrap ? '0 : (sy + 12'd1);
        end
    end

    // Decode sync, data enable and strobes from the next position.
    always_comb begin
        nx_ext           = {1'b0, next_sx};
        ny_ext           = {1'b0, next_sy};
        in_hsync         = (nx_ext >= H_SYNC_BEG) && (nx_ext < H_SYNC_END);
        in_vsync         = (ny_ext >= V_SYNC_BEG) && (ny_ext < V_SYNC_END);
        next_de          = (nx_ext < H_DE_END) && (ny_ext < V_DE_END);
        next_hsync       = SYNC_POL ? in_hsync : ~in_hsync;
        next_vsync       = SYNC_POL ? in_vsync : ~in_vsync;
        next_line_start  = (next_sx == '0);
        next_frame_start = (next_sx == '0) && (next_sy == '0);
    end

    // Output registers; reset parks on the last pixel of the frame so the
    // first cycle after release is (0,0) with both strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sx          <= H_LAST;
            sy          <= V_LAST;
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            sx          <= next_sx;
            sy          <= next_sy;
            de          <= next_de;
            hsync       <= next_hsync;
            vsync       <= next_vsync;
            line_start  <= next_line_start;
            frame_start <= next_frame_start;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic counting;

    // Count frame wraps, skipping the wrap that leaves reset so frame 1
    // reads 0 and the second frame_start coincides with frame_cnt=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            counting  <= 1'b0;
        end else if (h_wrap && v_wrap) begin
            if (counting) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            counting <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: table-driven reset/start vectors and line measurements on a
// default-mode instance, plus a cycle-by-cycle scoreboard against a small
// reference model on a reduced-size, active-high-sync instance.
module tb_vga_timing;

    typedef struct packed {
        logic [11:0] sx;
        logic [11:0] sy;
        logic        de;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct packed {
        logic rst;
        obs_t exp;
    } vec_t;

    // Reduced mode for the second instance: 25 x 15 total.
    localparam int H1A = 16, H1F = 2, H1S = 4, H1B = 3;
    localparam int V1A = 8,  V1F = 2, V1S = 2, V1B = 3;
    localparam int H1T = H1A + H1F + H1S + H1B;
    localparam int V1T = V1A + V1F + V1S + V1B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    logic [11:0] sx0, sy0, sx1, sy1;
    logic        hs0, vs0, de0, ls0, fs0;
    logic        hs1, vs1, de1, ls1, fs1;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
`endif

    vga_timing dut0 (
        .clk         (clk),
        .reset       (rst0),
        .sx          (sx0),
        .sy          (sy0),
        .hsync       (hs0),
        .vsync       (vs0),
        .de          (de0),
        .line_start  (ls0),
        .frame_start (fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (fc0)
`endif
    );

    vga_timing #(
        .H_ACTIVE (H1A),
        .H_FP     (H1F),
        .H_SYNC   (H1S),
        .H_BP     (H1B),
        .V_ACTIVE (V1A),
        .V_FP     (V1F),
        .V_SYNC   (V1S),
        .V_BP     (V1B),
        .SYNC_POL (1'b1)
    ) dut1 (
        .clk         (clk),
        .reset       (rst1),
        .sx          (sx1),
        .sy          (sy1),
        .hsync       (hs1),
        .vsync       (vs1),
        .de          (de1),
        .line_start  (ls1),
        .frame_start (fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (fc1)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    obs_t q0[$];
    obs_t q1[$];
    int   fs1_t[$];
    int   ls1_t[$];

    // Reference model state for dut1.
    int m1x = H1T - 1;
    int m1y = V1T - 1;
`ifdef VGA_TIMING_FRAME_CNT_EN
    int          m1_fs_seen = 0;
    logic [15:0] qf[$];
`endif

    function automatic string fmt(input obs_t o);
        return $sformatf("sx=%0d sy=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                         o.sx, o.sy, o.de, o.hs, o.vs, o.ls, o.fs);
    endfunction

    function automatic vec_t mk(input logic r, input int x, input int y,
                                input logic d, input logic h, input logic v,
                                input logic l, input logic f);
        vec_t t;
        t.rst    = r;
        t.exp.sx = 12'(x);
        t.exp.sy = 12'(y);
        t.exp.de = d;
        t.exp.hs = h;
        t.exp.vs = v;
        t.exp.ls = l;
        t.exp.fs = f;
        return t;
    endfunction

    task automatic cmp_obs(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s @cyc %0d: got {%s} want {%s}", name, cyc, fmt(act), fmt(exp));
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Advance the model one clock and queue what dut1 must show afterwards.
    task automatic model1(input logic r);
        obs_t e;
        if (r) begin
            m1x = H1T - 1;
            m1y = V1T - 1;
        end else begin
            m1x = m1x + 1;
            if (m1x == H1T) begin
                m1x = 0;
                m1y = (m1y + 1) % V1T;
            end
        end
        e.sx = 12'(m1x);
        e.sy = 12'(m1y);
        e.de = !r && (m1x < H1A) && (m1y < V1A);
        e.hs = !r && (m1x >= H1A + H1F) && (m1x < H1A + H1F + H1S);
        e.vs = !r && (m1y >= V1A + V1F) && (m1y < V1A + V1F + V1S);
        e.ls = !r && (m1x == 0);
        e.fs = !r && (m1x == 0) && (m1y == 0);
        q1.push_back(e);
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (r) m1_fs_seen = 0;
        else if (e.fs) m1_fs_seen++;
        qf.push_back((m1_fs_seen == 0) ? 16'd0 : 16'(m1_fs_seen - 1));
`endif
    endtask

    function automatic obs_t obs0();
        return '{sx: sx0, sy: sy0, de: de0, hs: hs0, vs: vs0, ls: ls0, fs: fs0};
    endfunction

    function automatic obs_t obs1();
        return '{sx: sx1, sy: sy1, de: de1, hs: hs1, vs: vs1, ls: ls1, fs: fs1};
    endfunction

    // One clock: drive resets at negedge, sample #1 after the rising edge.
    task automatic step(input logic r0, input logic r1, input bit chk0);
        obs_t e;
        @(negedge clk);
        rst0 = r0;
        rst1 = r1;
        model1(r1);
        @(posedge clk);
        #1;
        cyc++;
        if (chk0) begin
            if (q0.size() == 0) cmp_int("dut0_queue_empty", 0, 1);
            else begin
                e = q0.pop_front();
                cmp_obs("dut0_vec", obs0(), e);
            end
        end
        if (q1.size() == 0) cmp_int("dut1_queue_empty", 0, 1);
        else begin
            e = q1.pop_front();
            cmp_obs("dut1_cycle", obs1(), e);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (qf.size() != 0) cmp_int("dut1_frame_cnt", int'(fc1), int'(qf.pop_front()));
`endif
        if (fs1) fs1_t.push_back(cyc);
        if (ls1) ls1_t.push_back(cyc);
    endtask

    initial begin
        vec_t vecs[8];
        int de_cnt, hs_cnt, hs_first, hs_last;
        int ls0_t[$];
        bit found;

        // Reset 5 clocks, release, then the first two pixels of frame 1.
        for (int i = 0; i < 5; i++) vecs[i] = mk(1'b1, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[5] = mk(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[6] = mk(1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[7] = mk(1'b0, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            q0.push_back(vecs[i].exp);
            step(vecs[i].rst, vecs[i].rst, 1'b1);
`ifdef VGA_TIMING_FRAME_CNT_EN
            cmp_int("dut0_frame_cnt_start", int'(fc0), 0);
`endif
        end

        // Measure line 1 of the default mode and line_start spacing.
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 1700; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (sy0 == 12'd1) begin
                if (de0) de_cnt++;
                if (!hs0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(sx0);
                    hs_last = int'(sx0);
                end
            end
            if (ls0) ls0_t.push_back(cyc);
        end
        cmp_int("dut0_de_count", de_cnt, 640);
        cmp_int("dut0_hsync_count", hs_cnt, 96);
        cmp_int("dut0_hsync_first", hs_first, 656);
        cmp_int("dut0_hsync_last", hs_last, 751);
        cmp_int("dut0_line_period", (ls0_t.size() >= 2) ? ls0_t[1] - ls0_t[0] : -1, 800);
        cmp_int("dut1_line_period", (ls1_t.size() >= 2) ? ls1_t[1] - ls1_t[0] : -1, H1T);
        cmp_int("dut1_frame_period_a", (fs1_t.size() >= 3) ? fs1_t[1] - fs1_t[0] : -1, H1T * V1T);
        cmp_int("dut1_frame_period_b", (fs1_t.size() >= 3) ? fs1_t[2] - fs1_t[1] : -1, H1T * V1T);

        // Mid-line reset on dut0 at sx=300.
        found = 1'b0;
        for (int i = 0; i < 900 && !found; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (sx0 == 12'd300) found = 1'b1;
        end
        cmp_int("dut0_wait_sx300", int'(found), 1);
        step(1'b1, 1'b0, 1'b0);
        cmp_obs("dut0_midreset", obs0(), mk(1'b1, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0).exp);
        step(1'b0, 1'b0, 1'b0);
        cmp_obs("dut0_restart", obs0(), mk(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1).exp);

        // Mid-frame reset on dut1 at (10,5), then two more frames.
        found = 1'b0;
        for (int i = 0; i < 2 * H1T * V1T && !found; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (sx1 == 12'd10 && sy1 == 12'd5) found = 1'b1;
        end
        cmp_int("dut1_wait_10_5", int'(found), 1);
        step(1'b0, 1'b1, 1'b0);
        cmp_obs("dut1_midreset", obs1(), mk(1'b1, H1T - 1, V1T - 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0).exp);
        fs1_t.delete();
        step(1'b0, 1'b0, 1'b0);
        cmp_obs("dut1_restart", obs1(), mk(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1).exp);
        for (int i = 0; i < 2 * H1T * V1T + 5; i++) step(1'b0, 1'b0, 1'b0);
        cmp_int("dut1_frame_period_c", (fs1_t.size() >= 3) ? fs1_t[1] - fs1_t[0] : -1, H1T * V1T);
`ifdef VGA_TIMING_FRAME_CNT_EN
        cmp_int("dut1_frame_cnt_third", int'(fc1), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
